// File: rtl/div_seq.sv
// Sequential restoring divider for DIV/DIVU in the EX stage. Takes one step per cycle
// and requests a pipeline stall while a division is in flight.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [2*DATA_W:0]      work;
  logic [DATA_W-1:0]      divisor;
  logic                   sign1;
  logic                   sign2;
  logic                   sdiv;
  logic [DATA_W:0]        diff;
  logic signed [DATA_W-1:0] op1_s;
  logic signed [DATA_W-1:0] op2_s;
  logic                   neg1;
  logic                   neg2;

  function automatic logic [DATA_W-1:0] neg_if(input logic en, input logic [DATA_W-1:0] v);
    return en ? ({DATA_W{1'b0}} - v) : v;
  endfunction

  assign op1_s = opdata1_i;
  assign op2_s = opdata2_i;
  assign neg1  = signed_div_i & (op1_s < 0);
  assign neg2  = signed_div_i & (op2_s < 0);

  // Partial remainder lives in work[2W-1:W]; a borrow out of diff means "divisor does not fit".
  assign diff = {1'b0, work[2*DATA_W-1:DATA_W]} - {1'b0, divisor};

  assign stallreq_o = start_i & ~ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      ready_o  <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state   <= ON;
              cnt     <= '0;
              sign1   <= opdata1_i[DATA_W-1];
              sign2   <= opdata2_i[DATA_W-1];
              sdiv    <= signed_div_i;
              // Dividend sits one bit up so its MSB meets the divisor on the first step.
              work    <= {{DATA_W{1'b0}}, neg_if(neg1, opdata1_i), 1'b0};
              divisor <= neg_if(neg2, opdata2_i);
            end
          end
        end
        BYZERO: begin
          state    <= END;
          ready_o  <= 1'b1;
          result_o <= '0;
        end
        ON: begin
          if (annul_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end else if (cnt != LAST) begin
            if (diff[DATA_W]) work <= {work[2*DATA_W-1:0], 1'b0};
            else              work <= {diff[DATA_W-1:0], work[DATA_W-1:0], 1'b1};
            cnt <= cnt + CNT_W'(1);
          end else begin
            result_o <= {neg_if(sdiv & sign1, work[2*DATA_W:DATA_W+1]),
                         neg_if(sdiv & (sign1 ^ sign2), work[DATA_W-1:0])};
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        END: begin
          if (!start_i) begin
            state    <= FREE;
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: table of divisions with hand-computed results,
// plus annul/reset sequences mid-division.
module tb_div_seq;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           annul;
  logic           sdiv;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic [2*W-1:0] result;
  logic           ready;
  logic           stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           sd;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
    int             lat;
    bit             scramble;
  } vec_t;

  vec_t vecs[10];

  div_seq #(.DATA_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .annul_i      (annul),
    .signed_div_i (sdiv),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle in FREE.
  task automatic run_div(input string nm, input vec_t v, input int hold);
    int lat;
    int stalls;
    bit done;
    sdiv  = v.sd;
    op1   = v.a;
    op2   = v.b;
    annul = 1'b0;
    start = 1'b1;
    #1;
    stalls = stall ? 1 : 0;
    lat    = 0;
    done   = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready) done = 1'b1;
      else begin
        if (stall) stalls++;
        if (v.scramble) begin
          op1 = $urandom;
          op2 = $urandom;
        end
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(v.lat));
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(v.lat));
    chk({nm, "_result"}, result, v.exp);
    chk({nm, "_stall_after_ready"}, 64'(stall), 64'd0);
    for (int h = 0; h < hold; h++) begin
      annul = (h == 1);
      @(posedge clk);
      #1;
      chk({nm, "_hold_ready"}, 64'(ready), 64'd1);
      chk({nm, "_hold_result"}, result, v.exp);
    end
    annul = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_drop_ready"}, 64'(ready), 64'd0);
    chk({nm, "_drop_result"}, result, 64'd0);
  endtask

  initial begin
    bit   bad;
    vec_t v93;
    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 34, 1'b1};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        64'hFFFFFFFF_FFFFFFFD, 34, 1'b0};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFFFFF9,   32'd2,        64'h00000001_7FFFFFFC, 34, 1'b0};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0};
    vecs[5] = '{1'b0, 32'd5,          32'd0,        64'h00000000_00000000, 2,  1'b0};
    vecs[6] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34, 1'b0};
    vecs[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 34, 1'b0};
    vecs[8] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 34, 1'b0};
    vecs[9] = '{1'b1, 32'h80000000,   32'd0,        64'h00000000_00000000, 2,  1'b0};
    v93     = '{1'b0, 32'd9,          32'd3,        64'h00000000_00000003, 34, 1'b0};

    rst = 1'b1; start = 1'b0; annul = 1'b0; sdiv = 1'b0; op1 = '0; op2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++)
      run_div($sformatf("vec%0d", i), vecs[i], (i == 0) ? 5 : 2);

    // Annul partway through: must return to FREE and never produce a result.
    op1 = 32'd100; op2 = 32'd7; sdiv = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    annul = 1'b0;
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result", result, 64'd0);
    chk("annul_stall", 64'(stall), 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) bad = 1'b1;
    end
    chk("annul_idle_ready", 64'(bad), 64'd0);
    run_div("after_annul", v93, 2);

    // Synchronous reset mid-division.
    op1 = 32'd100; op2 = 32'd7; sdiv = 1'b0; start = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_result", result, 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ready) bad = 1'b1;
    end
    chk("midrst_idle_ready", 64'(bad), 64'd0);
    run_div("after_rst", v93, 2);

    // Reset while holding a finished result in END.
    op1 = 32'd6; op2 = 32'd3; sdiv = 1'b0; start = 1'b1;
    bad = 1'b1;
    for (int i = 0; i < 100 && bad; i++) begin
      @(posedge clk);
      #1;
      if (ready) bad = 1'b0;
    end
    chk("end_result_before_rst", result, 64'h00000000_00000002);
    rst = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("endrst_ready", 64'(ready), 64'd0);
    chk("endrst_result", result, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
